// File: rtl/gene_pkg.sv
// Shared nucleotide definitions: 2-bit base codes and the ASCII characters
// that map onto them.
package gene_pkg;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'b00;
    localparam base_t BASE_C = 2'b01;
    localparam base_t BASE_T = 2'b10;
    localparam base_t BASE_G = 2'b11;

    localparam logic [7:0] ASCII_A_UP = 8'h41;
    localparam logic [7:0] ASCII_C_UP = 8'h43;
    localparam logic [7:0] ASCII_G_UP = 8'h47;
    localparam logic [7:0] ASCII_T_UP = 8'h54;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
    localparam logic [7:0] ASCII_C_LO = 8'h63;
    localparam logic [7:0] ASCII_G_LO = 8'h67;
    localparam logic [7:0] ASCII_T_LO = 8'h74;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

endpackage

// File: rtl/ascii_base_decode.sv
// Combinational classifier: maps one ASCII byte to a 2-bit base code and
// flags whether it is a base, a silently skipped line terminator, or neither.
module ascii_base_decode
    import gene_pkg::*;
(
    input  logic [7:0] in_byte,
    output base_t      code,
    output logic       is_base,
    output logic       is_skip
);

    always_comb begin
        code    = BASE_A;
        is_base = 1'b0;
        is_skip = 1'b0;
        case (in_byte)
            ASCII_A_UP, ASCII_A_LO: begin
                code    = BASE_A;
                is_base = 1'b1;
            end
            ASCII_C_UP, ASCII_C_LO: begin
                code    = BASE_C;
                is_base = 1'b1;
            end
            ASCII_T_UP, ASCII_T_LO: begin
                code    = BASE_T;
                is_base = 1'b1;
            end
            ASCII_G_UP, ASCII_G_LO: begin
                code    = BASE_G;
                is_base = 1'b1;
            end
            ASCII_LF, ASCII_CR: begin
                is_skip = 1'b1;
            end
            default: begin
                code = BASE_A;
            end
        endcase
    end

endmodule

// File: rtl/ascii_base_packer.sv
// Packs a stream of ASCII nucleotides LSB-first into WORD_W-bit words of
// 2-bit codes, with a single-entry output register and illegal-byte counting.
module ascii_base_packer
    import gene_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = $clog2(WORD_W / 2) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              err_bad_char,
    output logic [15:0]       bad_count
);

    localparam int NB     = WORD_W / 2;
    localparam int FILL_W = CNT_W - 1;

    base_t code;
    logic  is_base;
    logic  is_skip;
    logic  is_illegal;

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;
    logic [15:0]       bad_q, bad_d;

    logic              accept;
    logic              word_full;
    logic              emit;
    logic [WORD_W-1:0] acc_ins;
    logic [CNT_W-1:0]  count_after;

    ascii_base_decode u_decode (
        .in_byte (in_data),
        .code    (code),
        .is_base (is_base),
        .is_skip (is_skip)
    );

    assign is_illegal = ~is_base & ~is_skip;
    assign in_ready   = ~out_valid_q | out_ready;
    assign accept     = in_valid & in_ready;

    // Bits above the fill point are always zero, so a flushed partial word
    // needs no masking.
    always_comb begin
        acc_ins                       = acc_q;
        acc_ins[{fill_q, 1'b0} +: 2]  = code;
        word_full   = is_base && (fill_q == FILL_W'(NB - 1));
        emit        = accept && (word_full || in_last);
        count_after = CNT_W'(fill_q) + (is_base ? CNT_W'(1) : CNT_W'(0));

        acc_d       = acc_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = accept && is_illegal;
        bad_d       = bad_q;

        if (emit) begin
            out_data_d  = is_base ? acc_ins : acc_q;
            out_count_d = count_after;
            out_valid_d = 1'b1;
            out_last_d  = in_last;
            acc_d       = '0;
            fill_d      = '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept && is_base) begin
                acc_d  = acc_ins;
                fill_d = fill_q + FILL_W'(1);
            end
        end

        if (accept && is_illegal && (bad_q != 16'hFFFF)) begin
            bad_d = bad_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            bad_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            bad_q       <= bad_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign err_bad_char = err_q;
    assign bad_count    = bad_q;

endmodule

// File: tb/tb_ascii_base_packer.sv
// Directed self-checking bench for ascii_base_packer with hand-computed
// expected words, backpressure and mid-word reset scenarios.
module tb_ascii_base_packer;

    localparam int WORD_W = 32;
    localparam int CNT_W  = $clog2(WORD_W / 2) + 1;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [WORD_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              err_bad_char;
    logic [15:0]       bad_count;

    int checks   = 0;
    int failures = 0;

    ascii_base_packer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .err_bad_char (err_bad_char),
        .bad_count    (bad_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Offers one byte from the falling edge and returns #1 after the
    // rising edge on which it was accepted.
    task automatic apply_stimulus(input logic [7:0] b, input logic last);
        int waited;
        @(negedge clk);
        in_data  = b;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_output("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_at_end);
        for (int i = 0; i < s.len(); i++) begin
            apply_stimulus(s[i], last_at_end && (i == s.len() - 1));
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] data,
                              input logic [31:0] count, input logic last);
        check_output({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check_output({tag, "_data"}, out_data, data);
        check_output({tag, "_count"}, {{(32-CNT_W){1'b0}}, out_count}, count);
        check_output({tag, "_last"}, {31'b0, out_last}, {31'b0, last});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_out_last", {31'b0, out_last}, 32'd0);
        check_output("rst_err", {31'b0, err_bad_char}, 32'd0);
        check_output("rst_out_data", out_data, 32'd0);
        check_output("rst_out_count", {{(32-CNT_W){1'b0}}, out_count}, 32'd0);
        check_output("rst_bad_count", {16'b0, bad_count}, 32'd0);
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Full word closed by last on the 16th base: no extra empty word.
        send_str("ACGTACGTACGTACGT", 1'b1);
        check_word("full_last", 32'hB4B4B4B4, 32'd16, 1'b1);
        idle_cycle();
        check_output("no_extra_word", {31'b0, out_valid}, 32'd0);

        send_str("GA", 1'b1);
        check_word("ga", 32'h00000003, 32'd2, 1'b1);
        idle_cycle();

        send_str("acgtacgtacgtacgt", 1'b0);
        check_word("lower_full", 32'hB4B4B4B4, 32'd16, 1'b0);
        send_str("A", 1'b1);
        check_word("lone_a", 32'h00000000, 32'd1, 1'b1);
        idle_cycle();

        apply_stimulus("A", 1'b0);
        apply_stimulus("N", 1'b0);
        check_output("err_pulse", {31'b0, err_bad_char}, 32'd1);
        check_output("bad_count_1", {16'b0, bad_count}, 32'd1);
        apply_stimulus(8'h0A, 1'b0);
        check_output("err_one_cycle", {31'b0, err_bad_char}, 32'd0);
        apply_stimulus("C", 1'b1);
        check_word("a_n_lf_c", 32'h00000004, 32'd2, 1'b1);
        check_output("bad_count_hold", {16'b0, bad_count}, 32'd1);
        idle_cycle();

        apply_stimulus(8'h0A, 1'b1);
        check_word("empty", 32'h00000000, 32'd0, 1'b1);
        idle_cycle();

        // Backpressure: word must hold and input must stall.
        out_ready = 1'b0;
        send_str("ACGTACGTACGTACGT", 1'b0);
        check_word("bp_word", 32'hB4B4B4B4, 32'd16, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle_cycle();
            check_output("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check_output("bp_hold_data", out_data, 32'hB4B4B4B4);
            check_output("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        apply_stimulus("G", 1'b1);
        check_word("bp_replace", 32'h00000003, 32'd1, 1'b1);
        idle_cycle();
        check_output("bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset mid-word discards the partial accumulator.
        send_str("ACG", 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("midrst_valid", {31'b0, out_valid}, 32'd0);
        check_output("midrst_bad_count", {16'b0, bad_count}, 32'd0);
        rst_n = 1'b1;
        send_str("ACGTACGTACGTACGT", 1'b1);
        check_word("post_rst", 32'hB4B4B4B4, 32'd16, 1'b1);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/ascii_base_packer.md
# ascii_base_packer

Streaming encoder that turns an ASCII nucleotide byte stream into packed 2-bit base codes, the inverse of the 2-bit-to-ASCII expansion path. Each accepted A/C/G/T byte (either case) maps to a 2-bit code and is packed LSB-first into a WORD_W-bit word. A full word is emitted when it fills; a partial word is emitted on end of record. The block sits between the byte-wide sequence ingest and the compression core.

## Interface
- WORD_W, 32: packed output width. Even, ≥ 4. Bases per word NB = WORD_W/2.
- CNT_W, $clog2(WORD_W/2)+1: width of out_count.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  ASCII character.
- in_valid  in  1  in_data/in_last are valid.
- in_ready  out  1  block accepts the byte this cycle.
- in_last  in  1  final character of the record.
- out_data  out  WORD_W  packed codes; base k is in bits [2k+1:2k].
- out_count  out  CNT_W  number of valid bases in out_data (0..NB).
- out_valid  out  1  output word is valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  word closes the record.
- err_bad_char  out  1  one-cycle pulse when an illegal byte is accepted.
- bad_count  out  16  saturating count of illegal bytes since reset.

## Operation
- Code map: A/a→2'b00, C/c→2'b01, T/t→2'b10, G/g→2'b11.
- Skip characters are 0x0A and 0x0D. They are consumed silently and produce no base.
- Any other byte is illegal. It is consumed and produces no base. It pulses err_bad_char and increments bad_count, which saturates at 0xFFFF.
- Internal state:
  - Accumulator acc[WORD_W-1:0].
  - Fill counter fill in the range 0..NB-1.
  - Single output register holding out_data, out_count, out_valid and out_last.
- Handshake: in_ready = ~out_valid | out_ready. This is combinational, and a byte is accepted when in_valid & in_ready.
- A legal base is written at acc[2·fill +: 2], and fill then increments.
- Emit condition (on accept):
  - The base brings fill to NB, or in_last=1.
  - The word loads into the output register with unfilled bits zero, out_count = bases in word, and out_last = in_last.
  - acc and fill then clear.
- in_last on a skip or illegal byte:
  - If fill>0, the partial word is flushed.
  - If fill=0, an empty word is emitted with out_count=0, out_data=0 and out_last=1, so every record ends with exactly one out_last word.
- Output register update:
  - Clears out_valid when out_valid & out_ready and there is no new emit in the same cycle.
  - When a drain and an emit occur in the same cycle, the new word replaces the old one and out_valid stays 1.
- While out_valid & ~out_ready, out_data, out_count and out_last hold stable.

## Timing
- Reset values:
  - out_valid, out_last, err_bad_char = 0.
  - out_data, out_count, bad_count, acc, fill = 0.
  - in_ready = 1 after reset, since out_valid=0.
- Latency: the byte completing a word is accepted in cycle t, and out_valid=1 in cycle t+1.
- Throughput: one byte per cycle when out_ready is held high.
- A full word appears every NB legal bases, plus skipped bytes.
- err_bad_char is registered and asserts in the cycle after the illegal byte is accepted.
- Reset asserted mid-word discards acc, fill and the pending output word immediately (asynchronous). No partial word is emitted.
- When fill=NB-1 and in_last=1 arrive on a legal base, one full word is emitted with out_count=NB and out_last=1. A second empty word is not emitted.

## Structure
- Shared package gene_pkg holds:
  - BASE_A/C/T/G 2-bit code constants.
  - ASCII constants for A,C,G,T,a,c,g,t, LF and CR.
  - base_t typedef (logic [1:0]).
- One combinational sub-module, ascii_base_decode:
  - Input: byte.
  - Outputs: code, is_base, is_skip.
  - Illegal = ~is_base & ~is_skip.
- The top module holds the accumulator, counter, output register and error counter.

## Test plan
- "ACGT" ×4 with in_last on the 16th byte and out_ready=1 → one word, out_data=0xB4B4B4B4, out_count=16, out_last=1, one cycle after the last accept.
- "GA" with in_last on 'A' → out_data=0x00000003, out_count=2, out_last=1.
- "acgt" ×4 (lowercase, no last), then "A" with last → words 0xB4B4B4B4 (count 16, last 0) and 0x00000000 (count 1, last 1).
- "A","N",LF,"C"(last) → err_bad_char pulses once, bad_count=1, out_data=0x00000004, out_count=2.
- LF with in_last and fill=0 → empty word: out_count=0, out_data=0, out_last=1.
- Backpressure: 16 bases with out_ready=0 → out_valid=1, in_ready=0, and out_data held 0xB4B4B4B4 for 10 cycles. With out_ready=1 and a legal byte offered in the same cycle → the old word is taken and the byte is accepted.
- Reset mid-word: 3 bases, then rst_n low for 2 cycles, then "ACGT"×4 → a single word 0xB4B4B4B4 with no stale bases.
